// File: rtl/lz77_job_scheduler.sv
// lz77_job_scheduler
//   Shares one LZ77 encode/decode engine between two requesters. Each job is
//   granted as a whole, and requesters take turns round-robin. A job has four
//   steps: pulse the engine reset, stream CHAR_NUM characters into the engine,
//   forward engine output beats tagged with the owner, and close the job when
//   the decoded END_CHAR terminator appears.
//
//   Optional feature: define LZ77_SCHED_WATCHDOG_EN to abort a job after
//   TIMEOUT consecutive RUN cycles without eng_valid. In the default build
//   (macro undefined) err is tied 0 and RUN waits for END_CHAR indefinitely.
//
// Ports
//   clk, reset    : single rising-edge clock, synchronous active-high reset
//   req[1:0]      : job request, one bit per requester
//   gnt[1:0]      : one-hot grant, held from KICK through DONE
//   load_en       : high in LOAD; the granted requester presents a char every cycle
//   src_data0/1   : character streams of requester 0 / 1
//   eng_reset     : engine reset (reset, KICK, or watchdog abort)
//   eng_chardata  : char to engine (owner's src_data in LOAD, else 0)
//   eng_valid     : engine output beat valid
//   eng_encode    : 1 = encode token beat, 0 = decoded character beat
//   eng_char_nxt  : decoded character of the current beat
//   tok_valid     : eng_valid forwarded during RUN only
//   tok_owner     : index of the current job owner
//   job_done      : one-cycle pulse when a job completes
//   err           : one-cycle pulse on watchdog abort
//   dbg_state     : current FSM state (debug observation)
//
// Handshake: there is no back-pressure anywhere. A beat moves on every cycle
// where its valid qualifier is high: load_en for the character stream into the
// engine, eng_valid for engine output, and tok_valid for forwarded output.
// Consumers must accept each beat in the cycle it is offered.

module lz77_job_scheduler #(
    parameter int          CHAR_NUM = 2048,
    parameter logic [7:0]  END_CHAR = 8'h24,
    parameter int          TO_W     = 16,
    parameter int          TIMEOUT  = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       load_en,
    input  logic [7:0] src_data0,
    input  logic [7:0] src_data1,
    output logic       eng_reset,
    output logic [7:0] eng_chardata,
    input  logic       eng_valid,
    input  logic       eng_encode,
    input  logic [7:0] eng_char_nxt,
    output logic       tok_valid,
    output logic       tok_owner,
    output logic       job_done,
    output logic       err,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(CHAR_NUM) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KICK = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    // Written on entry to KICK, so during a job it also names the owner.
    logic          last_owner_q, last_owner_d;
    logic          winner;
    logic          end_beat;
    logic          wd_fire;

    // Single requester wins outright; a tie goes to whoever did not own the last job.
    always_comb begin
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last_owner_q;
        endcase
    end

    assign end_beat = eng_valid & ~eng_encode & (eng_char_nxt == END_CHAR);

`ifdef LZ77_SCHED_WATCHDOG_EN
    logic [TO_W-1:0] wd_q, wd_d;

    // Counts consecutive silent RUN cycles; cleared by any beat or outside RUN.
    always_comb begin
        wd_d = '0;
        if (state_q == S_RUN && !eng_valid) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // A terminator arriving on the timeout cycle still completes the job normally.
    assign wd_fire = (state_q == S_RUN) && (wd_q == TO_W'(TIMEOUT)) && !end_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d      = S_KICK;
                    last_owner_d = winner;
                end
            end
            S_KICK: begin
                state_d    = S_LOAD;
                load_cnt_d = '0;
            end
            S_LOAD: begin
                // Counter holds at its last value on the final beat, so it never wraps.
                if (load_cnt_q == CW'(CHAR_NUM - 1)) begin
                    state_d = S_RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (end_beat) begin
                    state_d = S_DONE;
                end else if (wd_fire) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign load_en      = (state_q == S_LOAD);
    assign gnt          = (state_q == S_IDLE) ? 2'b00 : (last_owner_q ? 2'b10 : 2'b01);
    assign eng_reset    = reset | (state_q == S_KICK) | wd_fire;
    assign eng_chardata = load_en ? (last_owner_q ? src_data1 : src_data0) : 8'h00;
    assign tok_valid    = (state_q == S_RUN) & eng_valid;
    assign tok_owner    = last_owner_q;
    // Pulses are suppressed when reset lands on the same cycle.
    assign job_done     = (state_q == S_DONE) & ~reset;
    assign err          = wd_fire & ~reset;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_lz77_job_scheduler.sv
// Directed bench for lz77_job_scheduler with CHAR_NUM=8 and TIMEOUT=50. The
// engine is modelled behaviourally by driving eng_* beats directly.
module tb_lz77_job_scheduler;

    localparam int CHAR_NUM = 8;
    localparam int TIMEOUT  = 50;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KICK = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       load_en;
    logic [7:0] src_data0, src_data1;
    logic       eng_reset;
    logic [7:0] eng_chardata;
    logic       eng_valid, eng_encode;
    logic [7:0] eng_char_nxt;
    logic       tok_valid, tok_owner, job_done, err;
    logic [2:0] dbg_state;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_q[$];

    // Clock / reset block
    always #5 clk = ~clk;

    lz77_job_scheduler #(
        .CHAR_NUM (CHAR_NUM),
        .END_CHAR (8'h24),
        .TO_W     (16),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .gnt          (gnt),
        .load_en      (load_en),
        .src_data0    (src_data0),
        .src_data1    (src_data1),
        .eng_reset    (eng_reset),
        .eng_chardata (eng_chardata),
        .eng_valid    (eng_valid),
        .eng_encode   (eng_encode),
        .eng_char_nxt (eng_char_nxt),
        .tok_valid    (tok_valid),
        .tok_owner    (tok_owner),
        .job_done     (job_done),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one engine beat (inputs only; caller settles and checks).
    task automatic drive_beat(input logic v, input logic enc, input logic [7:0] ch);
        eng_valid    = v;
        eng_encode   = enc;
        eng_char_nxt = ch;
    endtask

    // Runs one job starting from an IDLE cycle and ends in the following IDLE cycle.
    // mode 0: normal job; mode 1: reset during RUN; mode 2: silent engine (watchdog).
    task automatic run_job(input logic [1:0] req_v, input int exp_owner,
                           input int drop_cycle, input int mode);
        logic [1:0] g;
        logic       enc_t[6];
        logic [7:0] ch_t[6];
        g = (exp_owner == 1) ? 2'b10 : 2'b01;
        // Encode tokens reuse the 8'h24 byte to show that only decoded beats terminate.
        enc_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ch_t  = '{8'h24, 8'h11, 8'h24, 8'h61, 8'h62, 8'h24};

        req = req_v;
        #1;
        check_eq("idle_state", 16'(dbg_state), 16'(ST_IDLE));
        check_eq("idle_gnt", 16'(gnt), 16'h0);
        tick();

        // KICK: a decoded terminator offered here must be discarded.
        drive_beat(1'b1, 1'b0, 8'h24);
        #1;
        check_eq("kick_state", 16'(dbg_state), 16'(ST_KICK));
        check_eq("kick_gnt", 16'(gnt), 16'(g));
        check_eq("kick_eng_reset", 16'(eng_reset), 16'h1);
        check_eq("kick_load_en", 16'(load_en), 16'h0);
        check_eq("kick_tok_valid", 16'(tok_valid), 16'h0);
        for (int i = 0; i < CHAR_NUM; i++) begin
            exp_q.push_back((exp_owner == 1) ? 8'(8'h40 + i) : 8'(8'h30 + i));
        end
        tick();

        for (int i = 0; i < CHAR_NUM; i++) begin
            src_data0 = 8'(8'h30 + i);
            src_data1 = 8'(8'h40 + i);
            if (i == drop_cycle) req = 2'b00;
            #1;
            check_eq("load_en", 16'(load_en), 16'h1);
            check_eq("load_gnt", 16'(gnt), 16'(g));
            check_eq("load_eng_reset", 16'(eng_reset), 16'h0);
            check_eq("load_tok_valid", 16'(tok_valid), 16'h0);
            check_eq("load_chardata", 16'(eng_chardata), 16'(exp_q.pop_front()));
            tick();
        end

        drive_beat(1'b0, 1'b0, 8'h00);
        #1;
        check_eq("run_state", 16'(dbg_state), 16'(ST_RUN));
        check_eq("run_load_en", 16'(load_en), 16'h0);
        check_eq("run_chardata", 16'(eng_chardata), 16'h0);
        check_eq("run_idle_tok", 16'(tok_valid), 16'h0);

`ifdef LZ77_SCHED_WATCHDOG_EN
        if (mode == 2) begin
            int early;
            early = 0;
            for (int c = 0; c < TIMEOUT; c++) begin
                if (err !== 1'b0 || dbg_state !== ST_RUN) early++;
                tick();
            end
            check_eq("wd_early", 16'(early), 16'h0);
            check_eq("wd_err", 16'(err), 16'h1);
            check_eq("wd_eng_reset", 16'(eng_reset), 16'h1);
            check_eq("wd_job_done", 16'(job_done), 16'h0);
            tick();
            check_eq("wd_after_state", 16'(dbg_state), 16'(ST_IDLE));
            check_eq("wd_after_gnt", 16'(gnt), 16'h0);
            check_eq("wd_after_err", 16'(err), 16'h0);
            check_eq("wd_after_done", 16'(job_done), 16'h0);
            return;
        end
`endif

        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                drive_beat(1'b0, 1'b0, 8'h24);
                #1;
                check_eq("run_gap_tok", 16'(tok_valid), 16'h0);
                tick();
            end
            drive_beat(1'b1, enc_t[k], ch_t[k]);
            #1;
            check_eq("run_tok_valid", 16'(tok_valid), 16'h1);
            check_eq("run_tok_owner", 16'(tok_owner), 16'(exp_owner));
            check_eq("run_state_beat", 16'(dbg_state), 16'(ST_RUN));
            check_eq("run_job_done", 16'(job_done), 16'h0);
            check_eq("run_err", 16'(err), 16'h0);
            if (mode == 1 && k == 1) begin
                reset = 1'b1;
                #1;
                check_eq("rst_eng_reset", 16'(eng_reset), 16'h1);
                tick();
                drive_beat(1'b0, 1'b0, 8'h00);
                #1;
                check_eq("rst_state", 16'(dbg_state), 16'(ST_IDLE));
                check_eq("rst_gnt", 16'(gnt), 16'h0);
                check_eq("rst_eng_reset2", 16'(eng_reset), 16'h1);
                check_eq("rst_job_done", 16'(job_done), 16'h0);
                check_eq("rst_err", 16'(err), 16'h0);
                reset = 1'b0;
                req   = 2'b00;
                tick();
                check_eq("rst_idle", 16'(dbg_state), 16'(ST_IDLE));
                return;
            end
            tick();
        end

        drive_beat(1'b0, 1'b0, 8'h00);
        #1;
        check_eq("done_state", 16'(dbg_state), 16'(ST_DONE));
        check_eq("done_pulse", 16'(job_done), 16'h1);
        check_eq("done_gnt", 16'(gnt), 16'(g));
        tick();
        check_eq("post_state", 16'(dbg_state), 16'(ST_IDLE));
        check_eq("post_gnt", 16'(gnt), 16'h0);
        check_eq("post_job_done", 16'(job_done), 16'h0);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 2'b00;
        src_data0 = 8'h00;
        src_data1 = 8'h00;
        drive_beat(1'b1, 1'b0, 8'h24);
        tick();
        tick();
        check_eq("rst_state0", 16'(dbg_state), 16'(ST_IDLE));
        check_eq("rst_gnt0", 16'(gnt), 16'h0);
        check_eq("rst_load_en0", 16'(load_en), 16'h0);
        check_eq("rst_job_done0", 16'(job_done), 16'h0);
        check_eq("rst_err0", 16'(err), 16'h0);
        check_eq("rst_eng_reset0", 16'(eng_reset), 16'h1);
        check_eq("rst_tok_valid0", 16'(tok_valid), 16'h0);
        check_eq("rst_chardata0", 16'(eng_chardata), 16'h0);
        reset = 1'b0;
        drive_beat(1'b0, 1'b0, 8'h00);
        tick();
        check_eq("idle_eng_reset", 16'(eng_reset), 16'h0);

        // Single requester 0, full job with tokens and decoded terminator.
        run_job(2'b01, 0, -1, 0);
        req = 2'b00;
        tick();

        // Both requesting from reset: 0, 1, 0 alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_job(2'b11, 0, -1, 0);
        run_job(2'b11, 1, -1, 0);
        run_job(2'b11, 0, -1, 0);
        req = 2'b00;
        tick();

        // Request dropped in LOAD cycle 4: job still completes.
        run_job(2'b01, 0, 4, 0);
        tick();

        // Reset during RUN, then a contest shows last_owner back at its reset value.
        run_job(2'b10, 1, -1, 1);
        run_job(2'b11, 0, -1, 0);
        req = 2'b00;
        tick();

`ifdef LZ77_SCHED_WATCHDOG_EN
        // Silent engine: watchdog abort keeps last_owner, so requester 0 wins next.
        run_job(2'b10, 1, -1, 2);
        run_job(2'b11, 0, -1, 0);
        req = 2'b00;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
